// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned RSP_ID_W = $clog2(NREQ);

  typedef enum logic {
    StInit,
    StRun
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the requesters (master) and mem_arbiter (slave).
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned AW    = 6
);
  import mem_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_err;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, init_done
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr_q;

  // One-hot grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves to the other requester after every grant, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (en && (grant != 2'b00)) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between two valid/ready requesters with
// round-robin arbitration and an OFFSET..OFFSET+DEPTH-1 address window.
// Define MEM_ARB_INIT_EN to zero-fill the window after reset before serving requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 80,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned OFFSET = 32,
  parameter int unsigned AW     = 6
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdata
);

  localparam logic [AW:0] RangeLo = (AW+1)'(OFFSET);
  localparam logic [AW:0] RangeHi = (AW+1)'(OFFSET + DEPTH);

`ifdef MEM_ARB_INIT_EN
  localparam int unsigned FillW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam arb_state_e  ResetState = StInit;
  logic [FillW-1:0] fill_q;
`else
  localparam arb_state_e  ResetState = StRun;
`endif

  arb_state_e          state_q;
  logic                init_done_q;
  logic [1:0]          grant;
  logic                accept;
  logic                gnt_id;
  logic [AW-1:0]       addr_sel;
  logic [WIDTH-1:0]    wdata_sel;
  logic                we_sel;
  logic                in_range;
  logic                rsp_vld_q;
  logic [RSP_ID_W-1:0] rsp_id_q;
  logic                rsp_err_q;
  logic                rsp_rd_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.req_valid),
    .en    (init_done_q),
    .grant (grant)
  );

  assign accept    = init_done_q && (bus.req_valid != '0);
  assign gnt_id    = grant[1];
  assign addr_sel  = gnt_id ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  assign wdata_sel = gnt_id ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
  assign we_sel    = bus.req_we[gnt_id];
  // Widened by one bit so OFFSET+DEPTH == 2^AW does not wrap.
  assign in_range  = ({1'b0, addr_sel} >= RangeLo) && ({1'b0, addr_sel} < RangeHi);

  assign bus.req_ready = init_done_q ? grant : 2'b00;
  assign bus.init_done = init_done_q;

  // Memory port steering: fill writes during INIT, granted in-range access in RUN.
  always_comb begin
    mem_ren   = 1'b0;
    mem_raddr = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
`ifdef MEM_ARB_INIT_EN
    // Gated by rst so the strobe stays low while reset is held.
    if ((state_q == StInit) && rst) begin
      mem_wen   = 1'b1;
      mem_waddr = RangeLo[AW-1:0] + AW'(fill_q);
    end
`endif
    if (accept && in_range) begin
      if (we_sel) begin
        mem_wen   = 1'b1;
        mem_waddr = addr_sel;
        mem_wdata = wdata_sel;
      end else begin
        mem_ren   = 1'b1;
        mem_raddr = addr_sel;
      end
    end
  end

  // INIT/RUN sequencing with the registered init_done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ResetState;
      init_done_q <= 1'b0;
`ifdef MEM_ARB_INIT_EN
      fill_q      <= '0;
`endif
    end else begin
      case (state_q)
        StRun: init_done_q <= 1'b1;
        default: begin
`ifdef MEM_ARB_INIT_EN
          fill_q <= fill_q + 1'b1;
          if (fill_q == FillW'(DEPTH - 1)) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
`else
          state_q <= StRun;
`endif
        end
      endcase
    end
  end

  // Response register: one-cycle strobe for every accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_vld_q <= accept;
      rsp_id_q  <= RSP_ID_W'(gnt_id);
      rsp_err_q <= accept && !in_range;
      rsp_rd_q  <= accept && in_range && !we_sel;
    end
  end

  assign bus.rsp_valid = rsp_vld_q ? (NREQ'(1) << rsp_id_q) : '0;
  assign bus.rsp_err   = rsp_err_q;
  // Read data arrives from the memory one cycle after the strobe.
  assign bus.rsp_rdata = rsp_rd_q ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one synchronous-read `mem` instance (WIDTH 80, DEPTH 32, OFFSET 32, SYNCREAD 1) between two requesters. Each requester uses a valid/ready request channel and an unbackpressured response strobe. The block round-robin arbitrates at most one memory access per cycle and range-checks addresses against the OFFSET window. Optionally, it zero-fills the memory after reset. It sits between the requester logic and the `mem` instance in the test/memory subsystem.

## Interface
- `WIDTH`, 80: data width.
- `DEPTH`, 32: number of entries.
- `OFFSET`, 32: first valid absolute address.
- `AW`, 6: address width. Must satisfy OFFSET+DEPTH ≤ 2^AW.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `req_valid` in 2: per-requester request valid; bit i belongs to requester i.
- `req_ready` out 2: per-requester accept.
- `req_we` in 2: 1 = write, 0 = read.
- `req_addr` in 2*AW: absolute addresses; requester i uses `[i*AW +: AW]`.
- `req_wdata` in 2*WIDTH: write data, sliced the same way.
- `rsp_valid` out 2: one-cycle response strobe.
- `rsp_err` out 1: response was out of range.
- `rsp_rdata` out WIDTH: read data; 0 for writes and errors.
- `mem_ren`, `mem_raddr[AW]`, `mem_rdata[WIDTH]` (in): mem read port.
- `mem_wen`, `mem_waddr[AW]`, `mem_wdata[WIDTH]`: mem write port.
- `init_done` out 1: high once the block accepts requests.

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT when MEM_ARB_INIT_EN is defined, otherwise RUN.
  - INIT goes to RUN after the last fill write. RUN has no exit except reset.
- INIT: writes 0 to addresses OFFSET … OFFSET+DEPTH-1 in order, one per cycle.
  - `req_ready` = 0 throughout; `init_done` = 0.
- RUN: `init_done` = 1.
- Grant rule:
  - If exactly one `req_valid` bit is high, that requester is granted.
  - If both are high, the requester indicated by the priority pointer is granted.
  - `req_ready[i]` = RUN & grant[i]; at most one bit is high.
  - `req_ready` may depend on `req_valid`. Requesters must not make valid depend on ready.
- Priority pointer:
  - Resets to requester 0.
  - After any grant to requester i, the pointer moves to 1-i.
  - The pointer holds when nothing is granted.
- Range check: in range means OFFSET ≤ addr < OFFSET+DEPTH. The check is computed in AW+1 bits so OFFSET+DEPTH cannot overflow.
- In-range read: `mem_ren` = 1, `mem_raddr` = addr.
- In-range write: `mem_wen` = 1, `mem_waddr` = addr, `mem_wdata` = the granted requester's data.
- Out of range: the request is still accepted, but no mem strobe is issued.
- Every accepted request produces exactly one response.
  - `rsp_valid[i]` is high for one cycle.
  - `rsp_err` = out-of-range flag.
  - `rsp_rdata` = `mem_rdata` for an in-range read, else 0.
- A requester may issue back-to-back requests. Its responses return in issue order.

## Timing
- Handshake: the request transfers in cycle T when `req_valid[i]` & `req_ready[i]`.
- Mem strobes are combinational in cycle T, in the same cycle as the handshake.
- Response: in cycle T+1. Fixed latency of 1; no response backpressure.
- Read-after-write from either requester in consecutive cycles returns the new data, because the write commits at the end of T.
- Reset values of outputs:
  - `req_ready` 0, `rsp_valid` 0, `rsp_err` 0, `rsp_rdata` 0, `init_done` 0.
  - All mem strobes 0.
  - With MEM_ARB_INIT_EN undefined, `init_done` rises at the first clock edge after reset release.
- Reset asserted mid-operation:
  - The pending response is dropped (`rsp_valid` forced to 0 immediately).
  - The INIT fill restarts from OFFSET.
  - The pointer returns to requester 0.
- Requests stalled during INIT stay pending and are served in RUN.

## Configuration
- `MEM_ARB_INIT_EN` defined:
  - The INIT fill is compiled in.
  - `init_done` rises exactly DEPTH cycles after reset release.
  - During INIT, `mem_wen` = 1 and `mem_wdata` = 0 every cycle.
- `MEM_ARB_INIT_EN` undefined:
  - No fill counter and no INIT state.
  - Memory content after reset is whatever `mem` holds.

## Structure
- Package `mem_arb_pkg`:
  - FSM state enum (INIT, RUN).
  - Requester count constant NREQ = 2.
  - Response-id width.
- Sub-module `rr_arb2`:
  - Two-input round-robin arbiter.
  - Inputs: valid[1:0] and an advance enable.
  - Outputs: one-hot grant[1:0].
  - Holds the pointer flop.
- The top level holds the FSM, fill counter, range check, mem muxing and the response register.

## Test plan
- Reset release with MEM_ARB_INIT_EN defined: expect 32 zero-writes to addresses 32..63, then `init_done` = 1 at cycle 32; afterwards a read of addr 45 returns 0.
- Requester 0 writes 0xABCD at addr 40; requester 1 reads addr 40 in the next cycle: the read response at T+1 is 0xABCD with `rsp_err` = 0.
- Both requesters valid continuously for 6 cycles: grants alternate 0,1,0,1,0,1; each gets 3 responses, each one cycle after its grant.
- Requester 1 reads addr 31 and addr 0x3F+1 wrapping (addr 0): both get `rsp_err` = 1 and `rsp_rdata` = 0, and no `mem_ren` pulse.
- Requester 0 reads addr 63, the upper boundary: `rsp_err` = 0. Requester 0 reads addr 32, the lower boundary: `rsp_err` = 0.
- Assert `rst` in the cycle after a grant: no `rsp_valid` appears, and after release INIT restarts at addr 32 with the pointer at 0.
